ac97_frame_transmitter: RTL

- Serializes AC'97 output frames to the codec: the mixed left/right sound samples plus codec register commands.
- Sits between the sound mixer and the codec's SDATA_OUT/SYNC pins.
- Generates the per-frame O_STROBE that the sound channels use as I_STROBE.
- Frame is 256 bits at 12.288 MHz BITCLK, which gives a 48 kHz frame rate.

---
 rtl/ac97_frame_transmitter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ac97_frame_transmitter.sv
// AC'97 output frame serializer.
// A free-running 8-bit frame counter walks the 256-bit frame.  Samples and the
// pending codec command are snapshotted into shadow registers at the end of
// the strobe cycle, so the frame on the wire never changes mid-transmission.
// All outputs are registered and computed one cycle ahead from bit_pos_d.
module ac97_frame_transmitter #(
    parameter int SAMPLE_WIDTH = 20
) (
    input  logic                    I_BITCLK,
    input  logic                    I_RESET,
    input  logic [SAMPLE_WIDTH-1:0] I_LEFT_SAMPLE,
    input  logic [SAMPLE_WIDTH-1:0] I_RIGHT_SAMPLE,
    input  logic                    I_CMD_VALID,
    input  logic                    I_CMD_READ,
    input  logic [6:0]              I_CMD_ADDR,
    input  logic [15:0]             I_CMD_DATA,
    output logic                    O_CMD_READY,
    output logic                    O_STROBE,
    output logic                    O_SYNC,
    output logic                    O_SDATA_OUT
);

    logic [7:0]  bit_pos_q, bit_pos_d;
    logic        strobe_q, strobe_d;
    logic        sync_q, sync_d;
    logic        sdata_q, sdata_d;

    // frame shadows (what the current frame transmits)
    logic [19:0] left_q, right_q;
    logic        cmd_vld_q, cmd_rd_q;
    logic [6:0]  cmd_addr_q;
    logic [15:0] cmd_data_q;

    // accepted command waiting for the next capture
    logic        pend_q, pend_d;
    logic        hold_rd_q;
    logic [6:0]  hold_addr_q;
    logic [15:0] hold_data_q;

    logic        accept;
    logic        capture;
    logic [19:0] left_just, right_just;
    logic [19:0] slot1, slot2;
    logic [4:0]  slot_idx;

    assign O_CMD_READY = ~pend_q;
    assign O_STROBE    = strobe_q;
    assign O_SYNC      = sync_q;
    assign O_SDATA_OUT = sdata_q;

    // Next-state: counter, handshake, and the frame bit for the next cycle
    always_comb begin
        bit_pos_d  = bit_pos_q + 8'd1;
        strobe_d   = (bit_pos_d == 8'd255);
        sync_d     = (bit_pos_d < 8'd16);
        capture    = (bit_pos_q == 8'd255);
        accept     = I_CMD_VALID & ~pend_q;

        pend_d = pend_q;
        if (capture) pend_d = 1'b0;
        if (accept)  pend_d = 1'b1;

        left_just  = '0;
        right_just = '0;
        left_just[19 -: SAMPLE_WIDTH]  = I_LEFT_SAMPLE;
        right_just[19 -: SAMPLE_WIDTH] = I_RIGHT_SAMPLE;

        slot1 = cmd_vld_q ? {cmd_rd_q, cmd_addr_q, 12'h000} : 20'h00000;
        slot2 = (cmd_vld_q & ~cmd_rd_q) ? {cmd_data_q, 4'h0} : 20'h00000;

        // Shadows only change on the 255->0 edge, where the next bit is the
        // constant frame-valid tag, so reading the _q shadows here is safe.
        slot_idx = 5'd0;
        sdata_d  = 1'b0;
        if (bit_pos_d == 8'd0) begin
            sdata_d = 1'b1;
        end else if (bit_pos_d == 8'd1 || bit_pos_d == 8'd2) begin
            sdata_d = cmd_vld_q;
        end else if (bit_pos_d == 8'd3 || bit_pos_d == 8'd4) begin
            sdata_d = 1'b1;
        end else if (bit_pos_d >= 8'd16 && bit_pos_d <= 8'd35) begin
            slot_idx = 5'(8'd35 - bit_pos_d);
            sdata_d  = slot1[slot_idx];
        end else if (bit_pos_d >= 8'd36 && bit_pos_d <= 8'd55) begin
            slot_idx = 5'(8'd55 - bit_pos_d);
            sdata_d  = slot2[slot_idx];
        end else if (bit_pos_d >= 8'd56 && bit_pos_d <= 8'd75) begin
            slot_idx = 5'(8'd75 - bit_pos_d);
            sdata_d  = left_q[slot_idx];
        end else if (bit_pos_d >= 8'd76 && bit_pos_d <= 8'd95) begin
            slot_idx = 5'(8'd95 - bit_pos_d);
            sdata_d  = right_q[slot_idx];
        end
    end

    // Frame counter and registered pin outputs
    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            bit_pos_q <= 8'd254;
            strobe_q  <= 1'b0;
            sync_q    <= 1'b0;
            sdata_q   <= 1'b0;
        end else begin
            bit_pos_q <= bit_pos_d;
            strobe_q  <= strobe_d;
            sync_q    <= sync_d;
            sdata_q   <= sdata_d;
        end
    end

    // Command holding register and frame shadows
    always_ff @(posedge I_BITCLK) begin
        if (I_RESET) begin
            pend_q      <= 1'b0;
            hold_rd_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            cmd_vld_q   <= 1'b0;
            cmd_rd_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
        end else begin
            pend_q <= pend_d;
            if (accept) begin
                hold_rd_q   <= I_CMD_READ;
                hold_addr_q <= I_CMD_ADDR;
                hold_data_q <= I_CMD_DATA;
            end
            if (capture) begin
                left_q    <= left_just;
                right_q   <= right_just;
                cmd_vld_q <= pend_q;
                if (pend_q) begin
                    cmd_rd_q   <= hold_rd_q;
                    cmd_addr_q <= hold_addr_q;
                    cmd_data_q <= hold_data_q;
                end
            end
        end
    end

endmodule
